// File: rtl/rx_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver.
// Latches the ALU result and hands it to the UART transmitter.
module rx_alu_interface #(
    parameter int NBITS        = 8,
    parameter int OPCODE_NBITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rx_done,
    input  logic [NBITS-1:0]        i_rx_data,
    input  logic [NBITS-1:0]        i_alu_result,
    input  logic                    i_tx_done,
    output logic [NBITS-1:0]        o_operand_a,
    output logic [NBITS-1:0]        o_operand_b,
    output logic [OPCODE_NBITS-1:0] o_opcode,
    output logic [NBITS-1:0]        o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        CAPTURE = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t                  state_reg, state_next;
    logic [NBITS-1:0]        operand_a_reg, operand_a_next;
    logic [NBITS-1:0]        operand_b_reg, operand_b_next;
    logic [OPCODE_NBITS-1:0] opcode_reg, opcode_next;
    logic [NBITS-1:0]        tx_data_reg, tx_data_next;
    logic                    tx_start_reg, tx_start_next;
    logic                    busy_reg, busy_next;

    // State and every output live in this one register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD_A;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
            opcode_reg    <= '0;
            tx_data_reg   <= '0;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            operand_a_reg <= operand_a_next;
            operand_b_reg <= operand_b_next;
            opcode_reg    <= opcode_next;
            tx_data_reg   <= tx_data_next;
            tx_start_reg  <= tx_start_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD_A:  if (i_rx_done) state_next = LOAD_B;
            LOAD_B:  if (i_rx_done) state_next = LOAD_OP;
            LOAD_OP: if (i_rx_done) state_next = CAPTURE;
            CAPTURE: state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_next = LOAD_A;
            default: state_next = LOAD_A;
        endcase
    end

    // Received bytes outside the load states fall through untouched, i.e. dropped.
    always_comb begin
        operand_a_next = operand_a_reg;
        operand_b_next = operand_b_reg;
        opcode_next    = opcode_reg;
        tx_data_next   = tx_data_reg;
        tx_start_next  = 1'b0;
        busy_next      = (state_next == CAPTURE) || (state_next == WAIT_TX);
        case (state_reg)
            LOAD_A:  if (i_rx_done) operand_a_next = i_rx_data;
            LOAD_B:  if (i_rx_done) operand_b_next = i_rx_data;
            LOAD_OP: if (i_rx_done) opcode_next = i_rx_data[OPCODE_NBITS-1:0];
            CAPTURE: begin
                tx_data_next  = i_alu_result;
                tx_start_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_operand_a = operand_a_reg;
    assign o_operand_b = operand_b_reg;
    assign o_opcode    = opcode_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_tx_start  = tx_start_reg;
    assign o_busy      = busy_reg;

endmodule

// File: tb/tb_rx_alu_interface.sv
// Bench for rx_alu_interface: a small external ALU plus a result scoreboard.
module tb_rx_alu_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_operand_a, o_operand_b, o_tx_data;
    logic [5:0] o_opcode;
    logic       o_tx_start, o_busy;

    int n_vec = 0;
    int n_err = 0;
    int pulse_count = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    rx_alu_interface #(.NBITS(8), .OPCODE_NBITS(6)) dut (
        .clk(clk), .rst(rst),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_operand_a(o_operand_a), .o_operand_b(o_operand_b),
        .o_opcode(o_opcode), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_busy(o_busy)
    );

    // External ALU: ADD, SUB, AND, OR; anything else yields zero.
    always_comb begin
        case (o_opcode)
            6'h20:   i_alu_result = o_operand_a + o_operand_b;
            6'h22:   i_alu_result = o_operand_a - o_operand_b;
            6'h24:   i_alu_result = o_operand_a & o_operand_b;
            6'h25:   i_alu_result = o_operand_a | o_operand_b;
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Scoreboard consumer: every start pulse must carry the oldest queued result.
    always @(posedge clk) begin
        #1;
        if (o_tx_start) begin
            pulse_count++;
            if (sb_q.size() == 0) begin
                chk("sb_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("sb_tx_data", {24'h0, o_tx_data}, {24'h0, sb_q.pop_front()});
                chk("sb_busy", {31'h0, o_busy}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        chk("operand_a", {24'h0, o_operand_a}, {24'h0, a});
        send_byte(b);
        chk("operand_b", {24'h0, o_operand_b}, {24'h0, b});
        sb_q.push_back(exp);
        send_byte(op);
        chk("opcode", {26'h0, o_opcode}, {26'h0, op[5:0]});
        chk("start_lat1", {31'h0, o_tx_start}, 32'd0);
        chk("busy_capture", {31'h0, o_busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("start_lat2", {31'h0, o_tx_start}, 32'd1);
        @(posedge clk);
        #1;
        chk("start_oneshot", {31'h0, o_tx_start}, 32'd0);
    endtask

    task automatic finish_tx();
        repeat (3) @(posedge clk);
        #1;
        chk("busy_wait", {31'h0, o_busy}, 32'd1);
        @(negedge clk);
        i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        i_tx_done = 1'b0;
        chk("busy_done", {31'h0, o_busy}, 32'd0);
    endtask

    initial begin
        int pulses_before;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_operand_a", {24'h0, o_operand_a}, 32'h0);
        chk("rst_operand_b", {24'h0, o_operand_b}, 32'h0);
        chk("rst_opcode", {26'h0, o_opcode}, 32'h0);
        chk("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
        chk("rst_tx_start", {31'h0, o_tx_start}, 32'h0);
        chk("rst_busy", {31'h0, o_busy}, 32'h0);
        repeat (20) @(posedge clk);
        #2;
        chk("idle_pulses", 32'(pulse_count), 32'd0);

        // Basic commands
        issue_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        finish_tx();
        issue_cmd(8'hFF, 8'h02, 8'h20, 8'h01);
        finish_tx();
        issue_cmd(8'h05, 8'h03, 8'hE0, 8'h08);
        finish_tx();
        issue_cmd(8'h0A, 8'h03, 8'h22, 8'h07);
        finish_tx();
        issue_cmd(8'hF0, 8'h3C, 8'h24, 8'h30);
        finish_tx();

        // tx_done outside WAIT_TX is ignored
        @(negedge clk);
        i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        i_tx_done = 1'b0;
        chk("stray_txdone_busy", {31'h0, o_busy}, 32'd0);

        // Dropped bytes during WAIT_TX and coincident with tx_done
        issue_cmd(8'h11, 8'h22, 8'h25, 8'h33);
        send_byte(8'hAA);
        chk("drop_wait_a", {24'h0, o_operand_a}, 32'h11);
        chk("drop_wait_busy", {31'h0, o_busy}, 32'd1);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = 8'hAA;
        i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        chk("drop_coinc_a", {24'h0, o_operand_a}, 32'h11);
        chk("drop_coinc_busy", {31'h0, o_busy}, 32'd0);
        issue_cmd(8'h01, 8'h01, 8'h20, 8'h02);
        finish_tx();

        // Reset mid-command
        send_byte(8'h09);
        send_byte(8'h09);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_operand_a", {24'h0, o_operand_a}, 32'h0);
        chk("midrst_operand_b", {24'h0, o_operand_b}, 32'h0);
        pulses_before = pulse_count;
        issue_cmd(8'h04, 8'h04, 8'h20, 8'h08);
        finish_tx();
        chk("midrst_pulses", 32'(pulse_count - pulses_before), 32'd1);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
